conv_strip_engine: RTL and testbench
====================================

Name: conv_strip_engine

Overview:
Multi-lane 2-D convolution engine for streamed image strips. Each input beat is one column slice of NB_LANES+KERNEL_WIDTH-1 vertically adjacent pixels. The block keeps a sliding KERNEL_WIDTH-column window and emits NB_LANES filtered pixels per beat once the window is full. It generalises the fixed 4-lane, 3x3, hard-wired-kernel convolver top: lane count and kernel size are parameters, the kernel is runtime-loadable and double-buffered with strip-boundary commit, and outputs carry a valid/strip-last pipeline.

Parameters:
NB_LANES, 4, output pixels per beat (one per row lane)
KERNEL_WIDTH, 3, kernel side; KERNEL_SIZE = KERNEL_WIDTH*KERNEL_WIDTH
NB_PIXEL, 8, unsigned pixel width
NB_COEFF, 8, signed coefficient width
FRAC_BITS, 6, coefficient fractional bits (2^FRAC_BITS = 1.0)
IMAGE_WIDTH, 200, columns per strip, zero padding included
NB_ROWS_IN, NB_LANES+KERNEL_WIDTH-1, pixels per input beat (derived)

Ports:
i_clk  in  1  clock
i_reset  in  1  reset; synchronous, active-high
i_data  in  NB_PIXEL*NB_ROWS_IN  column slice; row p at [p*NB_PIXEL +: NB_PIXEL], p=0 top
i_valid  in  1  i_data valid this cycle (no backpressure)
i_coeff_we  in  1  write shadow coefficient
i_coeff_addr  in  clog2(KERNEL_SIZE)  a = r*KERNEL_WIDTH + c; r = row offset, c = column offset (c=0 oldest column)
i_coeff_data  in  NB_COEFF  signed coefficient
i_kernel_commit  in  1  request shadow-to-active copy
o_kernel_pending  out  1  commit requested, not yet applied
o_data  out  NB_PIXEL*NB_LANES  lane l at [l*NB_PIXEL +: NB_PIXEL]
o_valid  out  1  o_data valid
o_strip_last  out  1  with o_valid: last output of strip

Behaviour:
- Reset: o_data=0, o_valid=0, o_strip_last=0, o_kernel_pending=0. Column counter=0, window cleared. Pipeline valids are flushed. Active and shadow kernels are set to identity (centre coeff = 2^FRAC_BITS, others 0). Reset mid-strip discards every in-flight result.
- Column counter: advances only on i_valid, over 0..IMAGE_WIDTH-1, and wraps to 0 after the last column. Gaps in i_valid are allowed and do not change results.
- Window: on i_valid the new column is shifted in. A beat at column index >= KERNEL_WIDTH-1 is productive, giving IMAGE_WIDTH-KERNEL_WIDTH+1 outputs per strip.
- Lane l uses input rows l..l+KERNEL_WIDTH-1 over the last KERNEL_WIDTH columns.
- Pipeline (fixed LATENCY=3 after the productive input beat):
  - S1: register window and valid.
  - S2: register the KERNEL_SIZE signed products. Each product is width NB_PIXEL+1+NB_COEFF, with the pixel zero-extended.
  - S3: sum the products, width +clog2(KERNEL_SIZE). Then add 2^(FRAC_BITS-1), arithmetic-shift right by FRAC_BITS, and saturate to [0, 2^NB_PIXEL-1] into the o_data register.
- o_valid/o_strip_last travel with the data. o_strip_last marks the beat for column IMAGE_WIDTH-1. o_data holds its value when o_valid=0.
- Kernel load:
  - i_coeff_we writes the shadow only; it never disturbs the active kernel.
  - On i_kernel_commit, o_kernel_pending rises the next cycle.
  - The copy happens when the column counter is 0 and no i_valid is present that cycle, or on the cycle the counter wraps to 0. So a strip is never split across kernels.
  - o_kernel_pending falls the cycle after the copy.
  - A coeff write in the same cycle as the copy is included in the copy.
  - A repeated commit while pending is absorbed.
- Products sample the active kernel at S1, so results in flight at a copy use the old kernel.

Decomposition:
- Package conv_pkg:
  - width helper functions (product and accumulator widths, clog2)
  - LATENCY=3 constant
  - identity-kernel constant function
  - coefficient address encoding
- Sub-module conv_lane_mac:
  - one lane's S2/S3 multiply, sum, round and saturate pipeline
  - instantiated NB_LANES times by a generate loop
  - kernel bank, counter and window stay in the top.

Test Plan:
Defaults except IMAGE_WIDTH=8.
1. Identity after reset: pixel(col,row)=10*col+row -> first o_valid 3 cycles after col 2 beat. Lane l = 11+l, then 21+l, and so on. 6 outputs, o_strip_last on the 6th (61+l).
2. Box kernel: all coeffs 7, committed while idle, constant pixel 64 -> every lane outputs 63 (9*7*64=4032>>6).
3. Saturation: all coeffs 127 with pixels 255 -> 255. All coeffs 0xC0 (-64) with pixels 255 -> 0.
4. Commit at column 3: o_kernel_pending stays high until the wrap. Strip 1 outputs are still identity; strip 2 uses the new kernel. Pending falls the cycle after the wrap.
5. Reset asserted with 2 results in flight -> o_valid=0 from the next cycle, no stale outputs. Kernel is identity again, and the next strip behaves like scenario 1.
6. Random i_valid gaps (~50% duty) with scenario 1 data -> identical o_data sequence, 6 valids per strip, latency 3 from each productive beat.

Source files
------------

// File: rtl/conv_pkg.sv
// conv_pkg: shared widths, constants and helpers for the strip convolution engine.
package conv_pkg;

    localparam int LATENCY = 3;

    typedef enum logic {
        K_IDLE    = 1'b0,
        K_PENDING = 1'b1
    } kload_state_t;

    function automatic int clog2_min1(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    // Signed product of a zero-extended pixel and a signed coefficient.
    function automatic int prod_width(input int nb_pixel, input int nb_coeff);
        return nb_pixel + 1 + nb_coeff;
    endfunction

    // Headroom for summing ksize products without overflow.
    function automatic int acc_width(input int nb_prod, input int ksize);
        return nb_prod + clog2_min1(ksize);
    endfunction

    // r = row offset, c = column offset (c = 0 is the oldest column).
    function automatic int coeff_addr(input int r, input int c, input int kernel_width);
        return r * kernel_width + c;
    endfunction

    // Pass-through kernel: centre tap is 1.0, everything else 0.
    function automatic int identity_coeff(input int a, input int kernel_width, input int frac_bits);
        return (a == coeff_addr(kernel_width / 2, kernel_width / 2, kernel_width)) ? (2 ** frac_bits) : 0;
    endfunction

endpackage

// File: rtl/conv_lane_mac.sv
// conv_lane_mac: one output lane's multiply (S2) and sum/round/saturate (S3) stages.
module conv_lane_mac
    import conv_pkg::*;
#(
    parameter int  KERNEL_WIDTH = 3,
    parameter int  NB_PIXEL     = 8,
    parameter int  NB_COEFF     = 8,
    parameter int  FRAC_BITS    = 6,
    localparam int KERNEL_SIZE  = KERNEL_WIDTH * KERNEL_WIDTH,
    localparam int NB_PROD      = prod_width(NB_PIXEL, NB_COEFF),
    localparam int NB_ACC       = acc_width(NB_PROD, KERNEL_SIZE)
) (
    input  logic                            i_clk,
    input  logic                            i_reset,
    input  logic                            i_s1_valid,
    input  logic                            i_s2_valid,
    input  logic [KERNEL_SIZE*NB_PIXEL-1:0] i_pixels,
    input  logic [KERNEL_SIZE*NB_COEFF-1:0] i_coeffs,
    output logic [NB_PIXEL-1:0]             o_pixel
);

    localparam logic signed [NB_ACC-1:0] ROUND_BIAS = NB_ACC'(2 ** (FRAC_BITS - 1));
    localparam logic signed [NB_ACC-1:0] PIX_MAX    = NB_ACC'(2 ** NB_PIXEL - 1);

    logic signed [NB_PROD-1:0] prod [KERNEL_SIZE];
    logic signed [NB_ACC-1:0]  acc;
    logic signed [NB_ACC-1:0]  scaled;

    // S2: one signed product per tap; the pixel is zero-extended so it never reads as negative.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            for (int k = 0; k < KERNEL_SIZE; k++)
                prod[k] <= '0;
        end else if (i_s1_valid) begin
            for (int k = 0; k < KERNEL_SIZE; k++)
                prod[k] <= $signed(NB_PROD'($signed({1'b0, i_pixels[k*NB_PIXEL +: NB_PIXEL]})))
                         * $signed(NB_PROD'($signed(i_coeffs[k*NB_COEFF +: NB_COEFF])));
        end
    end

    // S3 arithmetic: tap sum, round half up, drop the fractional bits.
    always_comb begin
        acc = '0;
        for (int k = 0; k < KERNEL_SIZE; k++)
            acc = acc + NB_ACC'(prod[k]);
        scaled = (acc + ROUND_BIAS) >>> FRAC_BITS;
    end

    // S3 register: clamp into the unsigned pixel range; holds between valid results.
    always_ff @(posedge i_clk) begin
        if (i_reset)
            o_pixel <= '0;
        else if (i_s2_valid) begin
            if (scaled[NB_ACC-1])
                o_pixel <= '0;
            else if (scaled > PIX_MAX)
                o_pixel <= '1;
            else
                o_pixel <= scaled[NB_PIXEL-1:0];
        end
    end

endmodule

// File: rtl/conv_strip_engine.sv
// conv_strip_engine: sliding-window multi-lane 2-D convolver for column-streamed image strips.
//
// Kernel-load FSM
//   state     | meaning
//   K_IDLE    | active kernel in use, no commit outstanding
//   K_PENDING | commit requested; shadow copies to active at the next strip boundary
module conv_strip_engine
    import conv_pkg::*;
#(
    parameter int  NB_LANES     = 4,
    parameter int  KERNEL_WIDTH = 3,
    parameter int  NB_PIXEL     = 8,
    parameter int  NB_COEFF     = 8,
    parameter int  FRAC_BITS    = 6,
    parameter int  IMAGE_WIDTH  = 200,
    localparam int NB_ROWS_IN   = NB_LANES + KERNEL_WIDTH - 1,
    localparam int KERNEL_SIZE  = KERNEL_WIDTH * KERNEL_WIDTH,
    localparam int NB_ADDR      = clog2_min1(KERNEL_SIZE)
) (
    input  logic                           i_clk,
    input  logic                           i_reset,
    input  logic [NB_PIXEL*NB_ROWS_IN-1:0] i_data,
    input  logic                           i_valid,
    input  logic                           i_coeff_we,
    input  logic [NB_ADDR-1:0]             i_coeff_addr,
    input  logic [NB_COEFF-1:0]            i_coeff_data,
    input  logic                           i_kernel_commit,
    output logic                           o_kernel_pending,
    output logic [NB_PIXEL*NB_LANES-1:0]   o_data,
    output logic                           o_valid,
    output logic                           o_strip_last
);

    localparam int                NB_COL     = clog2_min1(IMAGE_WIDTH);
    localparam logic [NB_COL-1:0] LAST_COL   = NB_COL'(IMAGE_WIDTH - 1);
    localparam logic [NB_COL-1:0] FIRST_PROD = NB_COL'(KERNEL_WIDTH - 1);

    logic [NB_COL-1:0]               col_cnt;
    logic                            at_last_col;
    logic                            coeff_wr_ok;
    logic [NB_PIXEL-1:0]             win [KERNEL_WIDTH][NB_ROWS_IN];
    logic signed [NB_COEFF-1:0]      shadow_k [KERNEL_SIZE];
    logic signed [NB_COEFF-1:0]      active_k [KERNEL_SIZE];
    logic signed [NB_COEFF-1:0]      s1_k     [KERNEL_SIZE];
    logic [KERNEL_SIZE*NB_COEFF-1:0] s1_k_flat;
    logic [LATENCY-1:0]              vld_sr;
    logic [LATENCY-1:0]              last_sr;
    kload_state_t                    kstate;
    kload_state_t                    kstate_nxt;
    logic                            copy_now;

    assign at_last_col = (col_cnt == LAST_COL);
    assign coeff_wr_ok = i_coeff_we && (32'(i_coeff_addr) < KERNEL_SIZE);

    // Column position within the strip; advances per accepted beat and wraps at the strip end.
    always_ff @(posedge i_clk) begin
        if (i_reset)
            col_cnt <= '0;
        else if (i_valid)
            col_cnt <= at_last_col ? '0 : col_cnt + 1'b1;
    end

    // Sliding column window, doubling as the S1 pixel register; column 0 is the oldest.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            for (int c = 0; c < KERNEL_WIDTH; c++)
                for (int p = 0; p < NB_ROWS_IN; p++)
                    win[c][p] <= '0;
        end else if (i_valid) begin
            for (int c = 0; c < KERNEL_WIDTH - 1; c++)
                for (int p = 0; p < NB_ROWS_IN; p++)
                    win[c][p] <= win[c+1][p];
            for (int p = 0; p < NB_ROWS_IN; p++)
                win[KERNEL_WIDTH-1][p] <= i_data[p*NB_PIXEL +: NB_PIXEL];
        end
    end

    // Valid and strip-last tags ride alongside the data through S1..S3.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            vld_sr  <= '0;
            last_sr <= '0;
        end else begin
            vld_sr  <= {vld_sr[LATENCY-2:0], i_valid && (col_cnt >= FIRST_PROD)};
            last_sr <= {last_sr[LATENCY-2:0], i_valid && at_last_col};
        end
    end

    assign o_valid      = vld_sr[LATENCY-1];
    assign o_strip_last = last_sr[LATENCY-1];

    // Shadow bank: host writes land here only.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            for (int k = 0; k < KERNEL_SIZE; k++)
                shadow_k[k] <= NB_COEFF'(identity_coeff(k, KERNEL_WIDTH, FRAC_BITS));
        end else if (coeff_wr_ok) begin
            for (int k = 0; k < KERNEL_SIZE; k++)
                if (i_coeff_addr == NB_ADDR'(k))
                    shadow_k[k] <= i_coeff_data;
        end
    end

    // Active bank: whole-kernel copy at the strip boundary, folding in a same-cycle host write.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            for (int k = 0; k < KERNEL_SIZE; k++)
                active_k[k] <= NB_COEFF'(identity_coeff(k, KERNEL_WIDTH, FRAC_BITS));
        end else if (copy_now) begin
            for (int k = 0; k < KERNEL_SIZE; k++)
                active_k[k] <= (coeff_wr_ok && i_coeff_addr == NB_ADDR'(k)) ? i_coeff_data : shadow_k[k];
        end
    end

    // Kernel snapshot taken with each window update, so in-flight beats keep the kernel they entered with.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            for (int k = 0; k < KERNEL_SIZE; k++)
                s1_k[k] <= NB_COEFF'(identity_coeff(k, KERNEL_WIDTH, FRAC_BITS));
        end else if (i_valid) begin
            for (int k = 0; k < KERNEL_SIZE; k++)
                s1_k[k] <= active_k[k];
        end
    end

    // Kernel-load state register.
    always_ff @(posedge i_clk) begin
        if (i_reset)
            kstate <= K_IDLE;
        else
            kstate <= kstate_nxt;
    end

    // Kernel-load next state; a commit seen while pending is simply absorbed.
    always_comb begin
        kstate_nxt = kstate;
        case (kstate)
            K_IDLE:    if (i_kernel_commit) kstate_nxt = K_PENDING;
            K_PENDING: if (copy_now)        kstate_nxt = K_IDLE;
            default:   kstate_nxt = K_IDLE;
        endcase
    end

    // Kernel-load outputs: copy only between strips, either idle at column 0 or on the wrapping beat.
    always_comb begin
        o_kernel_pending = (kstate == K_PENDING);
        copy_now         = (kstate == K_PENDING)
                        && ((col_cnt == '0 && !i_valid) || (i_valid && at_last_col));
    end

    // Flatten the S1 kernel snapshot for the lane MACs.
    always_comb begin
        s1_k_flat = '0;
        for (int k = 0; k < KERNEL_SIZE; k++)
            s1_k_flat[k*NB_COEFF +: NB_COEFF] = s1_k[k];
    end

    for (genvar l = 0; l < NB_LANES; l++) begin : g_lane
        logic [KERNEL_SIZE*NB_PIXEL-1:0] lane_pix;

        // Gather window rows l..l+KERNEL_WIDTH-1 in coefficient address order.
        always_comb begin
            lane_pix = '0;
            for (int r = 0; r < KERNEL_WIDTH; r++)
                for (int c = 0; c < KERNEL_WIDTH; c++)
                    lane_pix[coeff_addr(r, c, KERNEL_WIDTH)*NB_PIXEL +: NB_PIXEL] = win[c][l+r];
        end

        conv_lane_mac #(
            .KERNEL_WIDTH (KERNEL_WIDTH),
            .NB_PIXEL     (NB_PIXEL),
            .NB_COEFF     (NB_COEFF),
            .FRAC_BITS    (FRAC_BITS)
        ) u_mac (
            .i_clk      (i_clk),
            .i_reset    (i_reset),
            .i_s1_valid (vld_sr[0]),
            .i_s2_valid (vld_sr[1]),
            .i_pixels   (lane_pix),
            .i_coeffs   (s1_k_flat),
            .o_pixel    (o_data[l*NB_PIXEL +: NB_PIXEL])
        );
    end

endmodule

// File: tb/tb_conv_strip_engine.sv
// tb_conv_strip_engine: scoreboard bench for conv_strip_engine with an 8-column strip.
module tb_conv_strip_engine;

    localparam int NB_LANES    = 4;
    localparam int KW          = 3;
    localparam int KS          = KW * KW;
    localparam int NB_PIXEL    = 8;
    localparam int NB_COEFF    = 8;
    localparam int FRAC_BITS   = 6;
    localparam int IMAGE_WIDTH = 8;
    localparam int NB_ROWS_IN  = NB_LANES + KW - 1;
    localparam int NB_IN       = NB_PIXEL * NB_ROWS_IN;
    localparam int NB_OUT      = NB_PIXEL * NB_LANES;
    localparam int LAT         = 3;

    logic                clk = 1'b0;
    logic                rst;
    logic [NB_IN-1:0]    din;
    logic                vin;
    logic                we;
    logic [3:0]          caddr;
    logic [NB_COEFF-1:0] cdata;
    logic                commit;
    logic                pending;
    logic [NB_OUT-1:0]   dout;
    logic                ovalid;
    logic                olast;

    always #5 clk = ~clk;

    conv_strip_engine #(
        .NB_LANES     (NB_LANES),
        .KERNEL_WIDTH (KW),
        .NB_PIXEL     (NB_PIXEL),
        .NB_COEFF     (NB_COEFF),
        .FRAC_BITS    (FRAC_BITS),
        .IMAGE_WIDTH  (IMAGE_WIDTH)
    ) dut (
        .i_clk            (clk),
        .i_reset          (rst),
        .i_data           (din),
        .i_valid          (vin),
        .i_coeff_we       (we),
        .i_coeff_addr     (caddr),
        .i_coeff_data     (cdata),
        .i_kernel_commit  (commit),
        .o_kernel_pending (pending),
        .o_data           (dout),
        .o_valid          (ovalid),
        .o_strip_last     (olast)
    );

    typedef struct {
        logic [NB_OUT-1:0] data;
        logic              last;
        int                cyc;
    } exp_t;

    exp_t sb [$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   cyc      = 0;

    int   m_hist   [KW][NB_ROWS_IN];
    int   m_active [KS];
    int   m_shadow [KS];
    int   m_col;
    bit   m_pending;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp)
            n_pass++;
        else
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
    endtask

    function automatic int model_lane(input int l);
        int acc = 0;
        for (int r = 0; r < KW; r++)
            for (int c = 0; c < KW; c++)
                acc += m_hist[c][l+r] * m_active[r*KW + c];
        acc = (acc + 2 ** (FRAC_BITS - 1)) >>> FRAC_BITS;
        if (acc < 0)   return 0;
        if (acc > 255) return 255;
        return acc;
    endfunction

    function automatic logic [NB_IN-1:0] ramp_col(input int col);
        logic [NB_IN-1:0] s;
        for (int p = 0; p < NB_ROWS_IN; p++)
            s[p*NB_PIXEL +: NB_PIXEL] = NB_PIXEL'(10 * col + p);
        return s;
    endfunction

    function automatic logic [NB_IN-1:0] const_col(input int v);
        logic [NB_IN-1:0] s;
        for (int p = 0; p < NB_ROWS_IN; p++)
            s[p*NB_PIXEL +: NB_PIXEL] = NB_PIXEL'(v);
        return s;
    endfunction

    function automatic void model_init();
        m_col     = 0;
        m_pending = 1'b0;
        for (int c = 0; c < KW; c++)
            for (int p = 0; p < NB_ROWS_IN; p++)
                m_hist[c][p] = 0;
        for (int a = 0; a < KS; a++) begin
            m_active[a] = (a == KS / 2) ? 2 ** FRAC_BITS : 0;
            m_shadow[a] = m_active[a];
        end
    endfunction

    // One clock of stimulus; expected results are pushed as the beat is driven.
    task automatic drive(input bit v, input logic [NB_IN-1:0] d, input bit w,
                         input int a, input int cd, input bit cm);
        exp_t e;
        bit   copy;
        vin = v; din = d; we = w; caddr = 4'(a); cdata = NB_COEFF'(cd); commit = cm;
        if (v) begin
            for (int c = 0; c < KW - 1; c++)
                for (int p = 0; p < NB_ROWS_IN; p++)
                    m_hist[c][p] = m_hist[c+1][p];
            for (int p = 0; p < NB_ROWS_IN; p++)
                m_hist[KW-1][p] = int'(d[p*NB_PIXEL +: NB_PIXEL]);
            if (m_col >= KW - 1) begin
                e.data = '0;
                for (int l = 0; l < NB_LANES; l++)
                    e.data[l*NB_PIXEL +: NB_PIXEL] = NB_PIXEL'(model_lane(l));
                e.last = (m_col == IMAGE_WIDTH - 1);
                e.cyc  = cyc + LAT;
                sb.push_back(e);
            end
        end
        copy = m_pending && ((m_col == 0 && !v) || (v && m_col == IMAGE_WIDTH - 1));
        if (w) m_shadow[a] = cd;
        if (copy) begin
            for (int k = 0; k < KS; k++) m_active[k] = m_shadow[k];
            m_pending = 1'b0;
        end else if (cm) begin
            m_pending = 1'b1;
        end
        if (v) m_col = (m_col == IMAGE_WIDTH - 1) ? 0 : m_col + 1;
        @(posedge clk); #1;
        chk("kernel_pending", pending, m_pending);
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, '0, 1'b0, 0, 0, 1'b0);
    endtask

    task automatic beat(input logic [NB_IN-1:0] d);
        drive(1'b1, d, 1'b0, 0, 0, 1'b0);
    endtask

    // mode 0: all taps = v; mode 1: identity; mode 2: ramp 4+3a
    task automatic load_kernel(input int mode, input int v);
        int val;
        for (int a = 0; a < KS; a++) begin
            val = (mode == 0) ? v : (mode == 1) ? ((a == KS / 2) ? 64 : 0) : 4 + 3 * a;
            drive(1'b0, '0, 1'b1, a, val, 1'b0);
        end
    endtask

    task automatic commit_idle();
        drive(1'b0, '0, 1'b0, 0, 0, 1'b1);
        idle(2);
    endtask

    task automatic strip(input bit ramp, input int cval, input bit gaps);
        for (int col = 0; col < IMAGE_WIDTH; col++) begin
            if (gaps) idle(int'($urandom_range(0, 2)));
            beat(ramp ? ramp_col(col) : const_col(cval));
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; vin = 1'b0; we = 1'b0; commit = 1'b0; din = '0;
        @(posedge clk); #1;
        sb.delete();
        rst = 1'b0;
        model_init();
        chk("rst_o_valid", ovalid, 1'b0);
        chk("rst_o_data", dout, '0);
        chk("rst_o_strip_last", olast, 1'b0);
        chk("rst_pending", pending, 1'b0);
    endtask

    // Output monitor: every o_valid must match the oldest outstanding expectation.
    always @(negedge clk) begin
        exp_t e;
        if (ovalid === 1'b1) begin
            if (sb.size() == 0)
                chk("unexpected_o_valid", 1'b1, 1'b0);
            else begin
                e = sb.pop_front();
                chk("o_data", dout, e.data);
                chk("o_strip_last", olast, e.last);
                chk("latency_cycle", cyc, e.cyc);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; vin = 1'b0; we = 1'b0; commit = 1'b0; din = '0; caddr = '0; cdata = '0;
        @(posedge clk); #1;
        do_reset();

        // identity after reset
        strip(1'b1, 0, 1'b0);
        idle(4);

        // box kernel, constant 64 -> 63
        load_kernel(0, 7);
        commit_idle();
        strip(1'b0, 64, 1'b0);
        idle(4);

        // saturation high and low
        load_kernel(0, 127);
        commit_idle();
        strip(1'b0, 255, 1'b0);
        idle(4);
        load_kernel(0, -64);
        commit_idle();
        strip(1'b0, 255, 1'b0);
        idle(4);

        // commit mid-strip: repeat commit absorbed, write folded into the wrap copy
        load_kernel(1, 0);
        commit_idle();
        load_kernel(2, 0);
        for (int col = 0; col < IMAGE_WIDTH; col++)
            drive(1'b1, ramp_col(col), col == IMAGE_WIDTH - 1, 4, 40, col == 3 || col == 5);
        strip(1'b1, 0, 1'b0);
        idle(4);

        // reset with results in flight
        load_kernel(0, 7);
        commit_idle();
        for (int col = 0; col < 5; col++)
            beat(ramp_col(col));
        do_reset();
        idle(2);
        strip(1'b1, 0, 1'b0);
        idle(4);

        // random input gaps
        strip(1'b1, 0, 1'b1);
        strip(1'b1, 0, 1'b1);
        idle(6);

        chk("scoreboard_drained", 64'(sb.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
